quant_packer: RTL

//  Downstream neighbour of the requantizer: accepts requantized 18-bit samples
//  (MSB-aligned, Nquant significant bits) and packs only the top Nquant bits of

---
 rtl/quant_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/quant_packer.sv
// Packs the top Nq bits of each requantized 18-bit sample into a dense MSB-first
// stream of 32-bit words, buffered by a small first-word-fall-through word FIFO.
module quant_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  Nquant,
    input  logic [17:0] datain,
    input  logic        endatain,
    input  logic        flush,
    output logic [31:0] dataout,
    output logic        dataout_valid,
    input  logic        dataout_ready,
    output logic        overflow,
    output logic [5:0]  fill_level
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [49:0]   acc_q, acc_d, acc_rem;
    logic [5:0]    fill_q, fill_d, fill_rem;
    logic          pend_q, pend_d;
    logic          overflow_q, overflow_d;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_q, head_d;
    logic          valid_q, valid_d;

    logic [4:0]    nq;
    logic [17:0]   samp;
    logic          fifo_full, pop, push_full, push_flush, push, accept;
    logic [31:0]   push_word;

    always_comb begin
        nq = Nquant;
        if (Nquant == 5'd0)
            nq = 5'd1;
        else if (Nquant > 5'd18)
            nq = 5'd18;
    end

    assign samp       = datain & ~(18'h3FFFF >> nq);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = valid_q && dataout_ready;
    assign push_full  = (fill_q >= 6'd32) && !fifo_full;
    assign push_flush = pend_q && (fill_q != 6'd0) && (fill_q < 6'd32) && !fifo_full;
    assign push       = push_full || push_flush;
    // Bits below the fill point are always zero, so the residual word is already padded.
    assign push_word  = acc_q[49:18];

    always_comb begin
        acc_rem  = acc_q;
        fill_rem = fill_q;
        if (push_full) begin
            acc_rem  = acc_q << 32;
            fill_rem = fill_q - 6'd32;
        end else if (push_flush) begin
            acc_rem  = '0;
            fill_rem = 6'd0;
        end
    end

    assign accept = endatain && (fill_rem < 6'd32);

    always_comb begin
        acc_d      = acc_rem;
        fill_d     = fill_rem;
        overflow_d = overflow_q;
        pend_d     = pend_q;
        if (accept) begin
            acc_d  = acc_rem | ({samp, 32'd0} >> fill_rem);
            fill_d = fill_rem + {1'b0, nq};
        end
        if (endatain && !accept)
            overflow_d = 1'b1;
        // A sample landing on the clearing edge arrived while pending, so it stays pending.
        if (flush)
            pend_d = 1'b1;
        else if (pend_q && !accept && ((fill_q == 6'd0) || push_flush))
            pend_d = 1'b0;
    end

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        valid_d  = (count_d != '0);
        head_d   = mem[rd_ptr_d];
        if (count_d == '0)
            head_d = '0;
        else if ((count_q == '0) || (pop && (count_q == CW'(1))))
            head_d = push_word;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            fill_q     <= '0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
        end
    end

    assign dataout       = head_q;
    assign dataout_valid = valid_q;
    assign overflow      = overflow_q;
    assign fill_level    = fill_q;

endmodule
